// File: rtl/dcache_req_buffer_pkg.sv
// Shared definitions for the dcache request buffer: size codes, op codes,
// entry field widths and the buffered-entry layout.
package dcache_req_buffer_pkg;

  localparam int RBUF_ADDR_W = 32;
  localparam int RBUF_DATA_W = 32;
  localparam int RBUF_STRB_W = RBUF_DATA_W / 8;
  localparam int RBUF_LANE_W = $clog2(RBUF_STRB_W);
  localparam int RBUF_TYPE_W = 4;
  localparam int RBUF_CODE_W = 2;

  localparam logic [RBUF_TYPE_W-1:0] SIZE_BYTE = 4'b0001;
  localparam logic [RBUF_TYPE_W-1:0] SIZE_HALF = 4'b0011;
  localparam logic [RBUF_TYPE_W-1:0] SIZE_WORD = 4'b1111;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic [RBUF_ADDR_W-1:0] addr;
    logic [RBUF_TYPE_W-1:0] size;
    logic                   op;
    logic [RBUF_DATA_W-1:0] wdata;
    logic [RBUF_STRB_W-1:0] wstrb;
    logic                   uncache;
    logic                   cacop_en;
    logic [RBUF_CODE_W-1:0] cacop_code;
  } rbuf_ent_t;

  // Bit 0 is the M-valid flag, bit 1 the S-valid flag, so both come straight from flops.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_M     = 2'b01,
    OCC_MS    = 2'b11
  } rbuf_occ_e;

endpackage

// File: rtl/dcache_req_buffer_if.sv
// Request-side and rbuf-side signals of the dcache request buffer.
interface dcache_req_buffer_if
  import dcache_req_buffer_pkg::*;
#(
  parameter int ADDR_W = RBUF_ADDR_W,
  parameter int DATA_W = RBUF_DATA_W
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_op;
  logic [ADDR_W-1:0]      req_addr;
  logic [RBUF_TYPE_W-1:0] req_type;
  logic [DATA_W-1:0]      req_wdata;
  logic                   req_uncache;
  logic                   req_cacop_en;
  logic [RBUF_CODE_W-1:0] req_cacop_code;

  logic                   rbuf_valid;
  logic                   rbuf_ready;
  logic [ADDR_W-1:0]      addr_rbuf;
  logic [RBUF_TYPE_W-1:0] type_rbuf;
  logic                   op_rbuf;
  logic [DATA_W-1:0]      wdata_rbuf;
  logic [DATA_W/8-1:0]    wstrb_rbuf;
  logic                   uncache_rbuf;
  logic                   cacop_en_rbuf;
  logic [RBUF_CODE_W-1:0] cacop_code_rbuf;

  modport slave (
    input  req_valid, req_op, req_addr, req_type, req_wdata,
           req_uncache, req_cacop_en, req_cacop_code, rbuf_ready,
    output req_ready, rbuf_valid, addr_rbuf, type_rbuf, op_rbuf, wdata_rbuf,
           wstrb_rbuf, uncache_rbuf, cacop_en_rbuf, cacop_code_rbuf
  );

  modport master (
    output req_valid, req_op, req_addr, req_type, req_wdata,
           req_uncache, req_cacop_en, req_cacop_code, rbuf_ready,
    input  req_ready, rbuf_valid, addr_rbuf, type_rbuf, op_rbuf, wdata_rbuf,
           wstrb_rbuf, uncache_rbuf, cacop_en_rbuf, cacop_code_rbuf
  );

endinterface

// File: rtl/dcache_req_buffer_rbuf_entry_fmt.sv
// Capture-path formatter: moves store data to its byte lane and builds the
// write strobe so the buffered entry needs no further logic downstream.
module rbuf_entry_fmt
  import dcache_req_buffer_pkg::*;
(
  input  logic                   i_op,
  input  logic [RBUF_ADDR_W-1:0] i_addr,
  input  logic [RBUF_TYPE_W-1:0] i_size,
  input  logic [RBUF_DATA_W-1:0] i_wdata,
  input  logic                   i_uncache,
  input  logic                   i_cacop_en,
  input  logic [RBUF_CODE_W-1:0] i_cacop_code,
  output rbuf_ent_t              o_ent
);

  logic [RBUF_LANE_W-1:0] w_lane;
  logic [RBUF_STRB_W-1:0] w_strb_sh;

  assign w_lane = i_addr[RBUF_LANE_W-1:0];
  // Misaligned sizes shift strobe bits past the word; they are dropped here.
  assign w_strb_sh = RBUF_STRB_W'(i_size) << w_lane;

  always_comb begin
    o_ent            = '0;
    o_ent.addr       = i_addr;
    o_ent.size       = i_size;
    o_ent.op         = i_op;
    o_ent.wdata      = i_wdata << {w_lane, 3'b000};
    o_ent.wstrb      = (i_op == OP_WRITE && !i_cacop_en) ? w_strb_sh : '0;
    o_ent.uncache    = i_uncache;
    o_ent.cacop_en   = i_cacop_en;
    o_ent.cacop_code = i_cacop_code;
  end

endmodule

// File: rtl/dcache_req_buffer.sv
// Two-entry (main M + skid S) request buffer feeding the dcache FSM.
// Optional RBUF_PERF_CNT_EN adds the stall_cnt back-pressure counter port.
module dcache_req_buffer
  import dcache_req_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  dcache_req_buffer_if.slave bus
`ifdef RBUF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  rbuf_occ_e r_occ;
  rbuf_occ_e w_occ_nxt;
  logic      r_ready;
  rbuf_ent_t r_m;
  rbuf_ent_t r_s;
  rbuf_ent_t w_in_ent;
  logic      w_accept;
  logic      w_pop;
  logic      w_ld_m_in;
  logic      w_ld_m_s;
  logic      w_ld_s;

  rbuf_entry_fmt u_fmt (
    .i_op         (bus.req_op),
    .i_addr       (bus.req_addr),
    .i_size       (bus.req_type),
    .i_wdata      (bus.req_wdata),
    .i_uncache    (bus.req_uncache),
    .i_cacop_en   (bus.req_cacop_en),
    .i_cacop_code (bus.req_cacop_code),
    .o_ent        (w_in_ent)
  );

  assign w_accept = bus.req_valid & r_ready;
  assign w_pop    = r_occ[0] & bus.rbuf_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    w_ld_m_in = 1'b0;
    w_ld_m_s  = 1'b0;
    w_ld_s    = 1'b0;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_accept) begin
            w_ld_m_in = 1'b1;
            w_occ_nxt = OCC_M;
          end
        end
        OCC_M: begin
          if (w_pop) begin
            w_ld_m_in = w_accept;
            w_occ_nxt = w_accept ? OCC_M : OCC_EMPTY;
          end else if (w_accept) begin
            w_ld_s    = 1'b1;
            w_occ_nxt = OCC_MS;
          end
        end
        OCC_MS: begin
          // ready is low while S is full, so no accept can collide with the drain.
          if (w_pop) begin
            w_ld_m_s  = 1'b1;
            w_occ_nxt = OCC_M;
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ   <= OCC_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_occ   <= w_occ_nxt;
      r_ready <= ~w_occ_nxt[1];
    end
  end

  // Entry fields only toggle on capture; stale contents behind a clear valid are harmless.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_m_in) begin
        r_m <= w_in_ent;
      end else if (w_ld_m_s) begin
        r_m <= r_s;
      end
      if (w_ld_s) begin
        r_s <= w_in_ent;
      end
    end
  end

  assign bus.req_ready       = r_ready;
  assign bus.rbuf_valid      = r_occ[0];
  assign bus.addr_rbuf       = r_m.addr;
  assign bus.type_rbuf       = r_m.size;
  assign bus.op_rbuf         = r_m.op;
  assign bus.wdata_rbuf      = r_m.wdata;
  assign bus.wstrb_rbuf      = r_m.wstrb;
  assign bus.uncache_rbuf    = r_m.uncache;
  assign bus.cacop_en_rbuf   = r_m.cacop_en;
  assign bus.cacop_code_rbuf = r_m.cacop_code;

`ifdef RBUF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (bus.req_valid && !r_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
